// File: rtl/de_skid_pipe_reg_if.sv
// Decode-to-execute handshake bundle: Decode-side inputs,
// Execute-side outputs, flush and event counters.
interface de_skid_pipe_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NDATA  = 3,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      ctrl_d;
  logic [NDATA*WIDTH-1:0] data_d;
  logic [3:0]             wa3_d;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      ctrl_e;
  logic [NDATA*WIDTH-1:0] data_e;
  logic [3:0]             wa3_e;
  logic                   flush;
  logic                   clr_cnt;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       flush_cnt;

  modport master (
    output in_valid, ctrl_d, data_d, wa3_d,
    output out_ready, flush, clr_cnt,
    input  in_ready, out_valid, ctrl_e, data_e, wa3_e,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, ctrl_d, data_d, wa3_d,
    input  out_ready, flush, clr_cnt,
    output in_ready, out_valid, ctrl_e, data_e, wa3_e,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/de_skid_pipe_reg.sv
// Decode/Execute pipeline register with 2-entry skid buffer,
// flush with bubble masking and saturating stall/flush counters.
module de_skid_pipe_reg #(
  parameter int                WIDTH     = 32,
  parameter int                NDATA     = 3,
  parameter int                CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK = 16'h00FF,
  parameter int                CNT_W     = 16
) (
  input logic              clk,
  input logic              reset,
  de_skid_pipe_reg_if.slave bus
);
  localparam int DW = NDATA * WIDTH;

  logic              m_vld_q, m_vld_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DW-1:0]     m_data_q, m_data_d;
  logic [3:0]        m_wa3_q, m_wa3_d;
  logic              s_vld_q, s_vld_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DW-1:0]     s_data_q, s_data_d;
  logic [3:0]        s_wa3_q, s_wa3_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic in_rdy;
  logic in_fire;
  logic out_fire;
  logic stall_inc;
  logic flush_inc;

  // Ready comes only from a register, never from out_ready/flush.
  assign in_rdy    = !s_vld_q;
  assign in_fire   = bus.in_valid && in_rdy;
  assign out_fire  = m_vld_q && bus.out_ready;
  assign stall_inc = m_vld_q && !bus.out_ready && !bus.flush;
  assign flush_inc = bus.flush && (m_vld_q || s_vld_q);

  always_comb begin
    m_vld_d  = m_vld_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    m_wa3_d  = m_wa3_q;
    s_vld_d  = s_vld_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    s_wa3_d  = s_wa3_q;
    if (bus.flush) begin
      m_vld_d  = 1'b0;
      s_vld_d  = 1'b0;
      m_ctrl_d = m_ctrl_q & ~KILL_MASK;
      s_ctrl_d = s_ctrl_q & ~KILL_MASK;
    end else if (!m_vld_q || out_fire) begin
      if (s_vld_q) begin
        m_vld_d  = 1'b1;
        m_ctrl_d = s_ctrl_q;
        m_data_d = s_data_q;
        m_wa3_d  = s_wa3_q;
        s_vld_d  = 1'b0;
      end else if (in_fire) begin
        m_vld_d  = 1'b1;
        m_ctrl_d = bus.ctrl_d;
        m_data_d = bus.data_d;
        m_wa3_d  = bus.wa3_d;
      end else begin
        m_vld_d  = 1'b0;
      end
    end else if (in_fire) begin
      s_vld_d  = 1'b1;
      s_ctrl_d = bus.ctrl_d;
      s_data_d = bus.data_d;
      s_wa3_d  = bus.wa3_d;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (bus.clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stall_inc && stall_q != {CNT_W{1'b1}})
        stall_d = stall_q + 1'b1;
      if (flush_inc && flush_q != {CNT_W{1'b1}})
        flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_vld_q  <= 1'b0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      m_wa3_q  <= '0;
      s_vld_q  <= 1'b0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      s_wa3_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      m_wa3_q  <= m_wa3_d;
      s_vld_q  <= s_vld_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      s_wa3_q  <= s_wa3_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = m_vld_q;
  assign bus.ctrl_e    = m_vld_q ? m_ctrl_q
                                 : (m_ctrl_q & ~KILL_MASK);
  assign bus.data_e    = m_data_q;
  assign bus.wa3_e     = m_wa3_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_de_skid_pipe_reg.sv
// Scoreboard bench for de_skid_pipe_reg: directed streams,
// stalls, flushes, async reset and counter saturation.
module tb_de_skid_pipe_reg;
  localparam int W  = 32;
  localparam int N  = 3;
  localparam int C  = 16;
  localparam int CW = 4;
  localparam logic [C-1:0] KM = 16'h00FF;

  typedef struct packed {
    logic [C-1:0]   c;
    logic [N*W-1:0] d;
    logic [3:0]     w;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  de_skid_pipe_reg_if #(
    .WIDTH(W), .NDATA(N), .CTRL_W(C), .CNT_W(CW)
  ) bus ();

  de_skid_pipe_reg #(
    .WIDTH(W), .NDATA(N), .CTRL_W(C),
    .KILL_MASK(KM), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  item_t sb[$];
  int    got[$];
  int    n_cmp = 0;
  int    n_err = 0;
  item_t mon_e;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mk(int v);
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++)
      d[k*W +: W] = W'(v + k * 256);
    return d;
  endfunction

  // Issue side: every accepted instruction becomes an expectation.
  always @(negedge clk) begin
    if (!reset || bus.flush)
      sb.delete();
    else if (bus.in_valid && bus.in_ready)
      sb.push_back({bus.ctrl_d, bus.data_d, bus.wa3_d});
  end

  // Monitor side: every Execute-side transfer pops one expectation.
  always @(negedge clk) begin
    if (reset && !bus.flush &&
        bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: actual %0h required none",
                 bus.data_e[W-1:0]);
      end else begin
        mon_e = sb.pop_front();
        chk("out_item",
            {bus.ctrl_e, bus.data_e, bus.wa3_e}, mon_e);
        got.push_back(int'(bus.data_e[W-1:0]));
      end
    end
  end

  task automatic put(bit iv, int v, logic [C-1:0] c);
    bus.in_valid = iv;
    bus.ctrl_d   = c;
    bus.data_d   = mk(v);
    bus.wa3_d    = v[3:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(string nm, int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    if (got.size() == exp.size())
      foreach (exp[i]) chk(nm, got[i], exp[i]);
    got.delete();
  endtask

  initial begin
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.clr_cnt   = 1'b0;
    put(0, 0, '0);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_ctrl_e", bus.ctrl_e, 0);
    chk("rst_data_e", bus.data_e, 0);
    chk("rst_wa3_e", bus.wa3_e, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_cnt", bus.flush_cnt, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Streaming
    bus.out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      put(1, v, 16'hA500 | 16'(v));
      if (v > 1) begin
        chk("stream_valid", bus.out_valid, 1);
        chk("stream_word0", bus.data_e[W-1:0], v - 1);
      end
      tick();
    end
    put(0, 0, '0);
    tick();
    tick();
    chk_seq("stream_seq", '{1, 2, 3, 4});
    chk("stream_stall_cnt", bus.stall_cnt, 0);

    // Stall with skid capture
    put(1, 10, 16'h0A0A);
    tick();
    put(1, 11, 16'h0B0B);
    tick();
    put(1, 12, 16'h0C0C);
    bus.out_ready = 1'b0;
    tick();
    chk("skid_ready_c1", bus.in_ready, 0);
    put(0, 0, '0);
    tick();
    chk("skid_ready_c2", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("skid_ready_back", bus.in_ready, 1);
    tick();
    tick();
    chk_seq("skid_seq", '{10, 11, 12});
    chk("skid_stall_cnt", bus.stall_cnt, 2);

    // Flush with full skid and pending input
    bus.out_ready = 1'b0;
    put(1, 20, 16'hFFFF);
    tick();
    put(1, 21, 16'hFFFF);
    tick();
    chk("fl_skid_full", bus.in_ready, 0);
    put(1, 22, 16'hFFFF);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    put(0, 0, '0);
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_ctrl_masked", bus.ctrl_e, 16'hFF00);
    chk("fl_flush_cnt", bus.flush_cnt, 1);
    chk("fl_stall_cnt", bus.stall_cnt, 3);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_seq("fl_seq", '{});

    // Flush discards a same-cycle in_fire
    bus.out_ready = 1'b0;
    put(1, 60, 16'h3C3C);
    tick();
    put(1, 61, 16'h3D3D);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    put(0, 0, '0);
    chk("fl2_out_valid", bus.out_valid, 0);
    chk("fl2_flush_cnt", bus.flush_cnt, 2);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_seq("fl2_seq", '{});

    // Flush while empty
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fle_flush_cnt", bus.flush_cnt, 2);
    chk("fle_out_valid", bus.out_valid, 0);

    // Async reset mid-stall
    bus.out_ready = 1'b0;
    put(1, 30, 16'h1E1E);
    tick();
    put(1, 31, 16'h1F1F);
    tick();
    put(0, 0, '0);
    #1 reset = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_in_ready", bus.in_ready, 1);
    chk("ar_ctrl_e", bus.ctrl_e, 0);
    chk("ar_data_e", bus.data_e, 0);
    chk("ar_wa3_e", bus.wa3_e, 0);
    chk("ar_stall_cnt", bus.stall_cnt, 0);
    chk("ar_flush_cnt", bus.flush_cnt, 0);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    put(1, 40, 16'h1234);
    tick();
    chk("ar_first_valid", bus.out_valid, 1);
    chk("ar_first_word0", bus.data_e[W-1:0], 40);
    put(0, 0, '0);
    tick();
    chk_seq("ar_seq", '{40});

    // Counter saturation and clear priority
    bus.out_ready = 1'b0;
    put(1, 50, 16'h3232);
    tick();
    put(0, 0, '0);
    repeat (20) tick();
    chk("sat_stall_cnt", bus.stall_cnt, 15);
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    chk("clr_stall_cnt", bus.stall_cnt, 0);
    tick();
    chk("post_clr_stall", bus.stall_cnt, 1);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_seq("sat_seq", '{50});
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/de_skid_pipe_reg.md
# de_skid_pipe_reg

Parametrised decode-to-execute pipeline register for the pipelined processor. It carries a generic control bundle, NDATA datapath words and the destination register field from Decode to Execute. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush with bubble insertion, and saturating stall/flush event counters. Execute-side stalls therefore back-pressure Decode without a combinational ready path, and branch or hazard flushes never leak side effects.

## Interface
- WIDTH, 32: datapath word width.
- NDATA, 3: number of datapath words carried (e.g. SrcA, WriteData, ExtImm).
- CTRL_W, 16: control bundle width.
- KILL_MASK, 16'h00FF: CTRL_W-bit mask of side-effecting control bits (RegWrite, MemWrite, FlagWrite, PCSrc, Branch); these bits are forced to 0 whenever the stage holds a bubble.
- CNT_W, 16: counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset == 0 resets).
- in_valid  in  1  Decode presents an instruction.
- in_ready  out  1  stage can accept; equals !skid_valid (registered source only).
- ctrl_d  in  CTRL_W  control bundle from Decode.
- data_d  in  NDATA*WIDTH  datapath words; word k is at [k*WIDTH +: WIDTH].
- wa3_d  in  4  destination register.
- out_valid  out  1  Execute-side instruction valid.
- out_ready  in  1  Execute accepts / not stalled.
- ctrl_e  out  CTRL_W  control to Execute.
- data_e  out  NDATA*WIDTH  datapath words to Execute.
- wa3_e  out  4  destination register to Execute.
- flush  in  1  kill all held instructions (branch taken / load-use bubble).
- clr_cnt  in  1  synchronous counter clear.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.
- flush_cnt  out  CNT_W  flush cycles that killed at least one instruction.

## Operation
- State: main register {out_valid, ctrl, data, wa3} and skid register {skid_valid, ctrl, data, wa3}. Invariant: skid_valid implies out_valid.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Priority per cycle: reset > flush > normal transfer.
- Normal transfer:
  - If !out_valid or out_fire, main loads from skid when skid_valid is set (skid_valid clears). Otherwise main loads from the input when in_fire. Otherwise out_valid is set to 0.
  - If out_valid and !out_ready and in_fire, the input is captured into skid and skid_valid is set.
  - in_fire with skid_valid cannot occur, because in_ready is 0.
- Flush: out_valid and skid_valid are set to 0, the held ctrl has KILL_MASK bits zeroed, and any in_fire in the same cycle is discarded. The flush overrides out_ready.
- Bubble masking: while out_valid == 0, ctrl_e = ctrl & ~KILL_MASK. The non-masked ctrl bits, data_e and wa3_e keep their last values and are don't-care.
- Counters saturate at 2^CNT_W-1 and do not wrap.
  - stall_cnt increments when out_valid && !out_ready && !flush.
  - flush_cnt increments when flush && (out_valid || skid_valid).
  - clr_cnt clears both counters and overrides any increment in the same cycle.

## Timing
- Reset: out_valid=0, skid_valid=0, in_ready=1, ctrl_e/data_e/wa3_e=0, stall_cnt=0, flush_cnt=0. These values apply immediately on assertion, independent of clk.
- Reset mid-operation discards both entries. The first in_fire after reset release appears at the output the next cycle.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty or out_fire occurs.
- Throughput: 1 instruction/cycle while out_ready=1. in_ready never depends combinationally on out_ready or flush.
- After a single-cycle stall with continuous input: skid fills, in_ready drops the next cycle, and it returns to 1 one cycle after the skid drains.
- Order is preserved; the skid entry always leaves before any newer input.
- Flush takes effect at the edge where it is sampled. out_valid=0 and in_ready=1 in the following cycle.

## Test plan
- Streaming: out_ready=1, in_valid=1 with data word0 = 1,2,3,4 -> out_valid from cycle 1, data_e word0 = 1,2,3,4 on consecutive cycles, stall_cnt=0.
- Stall and skid: stream 10,11,12 and drop out_ready for 2 cycles while 11 is at the output -> 12 is captured in skid, in_ready=0 for 2 cycles, output sequence 10,11,12 with no loss or duplication, stall_cnt=2.
- Flush with full skid: out=20, skid=21, flush=1 with in_valid=1 (value 22) -> next cycle out_valid=0, in_ready=1, 22 dropped, KILL_MASK bits of ctrl_e=0, flush_cnt=1.
- Flush when empty: flush=1 with out_valid=0 -> flush_cnt unchanged, no output.
- Asynchronous reset mid-stall: skid full, reset=0 between clock edges -> out_valid, skid_valid and all outputs 0 immediately, in_ready=1.
- Counter saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15. clr_cnt=1 together with a stall cycle -> stall_cnt=0.
